// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field positions, constants and the sequential-unit FSM states.
package fp32_pkg;
  localparam int SIGN     = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;
  localparam int MANT_LSB = 0;

  localparam int          BIAS      = 127;
  localparam int          MANT_W    = 24;
  localparam logic [7:0]  EXP_MAX   = 8'hFF;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } fp32_t;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} fsm_state_t;
endpackage

// File: rtl/mant_mul_seq.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, done pulses after W steps.
module mant_mul_seq
  import fp32_pkg::*;
#(
  parameter int W = MANT_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int CW = $clog2(W);

  logic [W-1:0]  mcand, acc_hi, mplier;
  logic [CW-1:0] cnt;
  logic          run;
  logic [W:0]    sum;

  assign sum  = {1'b0, acc_hi} + (mplier[0] ? {1'b0, mcand} : '0);
  // Consumed multiplier bits are replaced by low product bits as the pair shifts right.
  assign prod = {acc_hi, mplier};

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc_hi <= '0;
      mplier <= '0;
      cnt    <= '0;
      run    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand  <= a;
        mplier <= b;
        acc_hi <= '0;
        cnt    <= '0;
        run    <= 1'b1;
      end else if (run) begin
        acc_hi <= sum[W:1];
        mplier <= {sum[0], mplier[W-1:1]};
        cnt    <= cnt + 1'b1;
        if (cnt == CW'(W-1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/multiplication_fp_seq.sv
// Multi-cycle FP32 multiplier (truncating, flush-to-zero, saturating) feeding the Q-update adder.
module multiplication_fp_seq
  import fp32_pkg::*;
#(
  parameter int BIAS   = fp32_pkg::BIAS,
  parameter int MANT_W = fp32_pkg::MANT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InA,
  input  logic [31:0] InB,
  input  logic        valid_in,
  output logic        busy,
  output logic [31:0] Product,
  output logic        valid_out
);
  fsm_state_t state, state_nxt;
  fp32_t      a, b;
  logic       accept;
  logic       sign_r, zero_r;
  logic signed [9:0] esum_r, e_adj;
  logic [2*MANT_W-1:0] p;
  logic       mul_done;
  logic [22:0] mant;
  logic [31:0] result;
  logic       unused_lsb;

  assign a = InA;
  assign b = InB;
  assign accept = valid_in && (state == IDLE || state == DONE);

  mant_mul_seq #(.W(MANT_W)) u_core (
    .clk   (clk),
    .rst   (rst),
    .start (accept),
    .a     ({1'b1, a.mant}),
    .b     ({1'b1, b.mant}),
    .done  (mul_done),
    .prod  (p)
  );

  // A product of two 1.x mantissas lies in [1,4): bit 47 selects the extra exponent step.
  assign mant       = p[47] ? p[46:24] : p[45:23];
  assign e_adj      = esum_r - 10'(BIAS) + {9'd0, p[47]};
  assign unused_lsb = ^p[22:0];

  always_comb begin
    result = {sign_r, EXP_MAX, 23'd0};
    if (zero_r)                result = {sign_r, 31'd0};
    else if (e_adj >= 10'sd255) result = {sign_r, EXP_MAX, 23'd0};
    else if (e_adj <= 10'sd0)   result = {sign_r, 31'd0};
    else                        result = {sign_r, e_adj[7:0], mant};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sign_r  <= 1'b0;
      zero_r  <= 1'b0;
      esum_r  <= '0;
      Product <= FP32_ZERO;
    end else begin
      state <= state_nxt;
      if (accept) begin
        sign_r <= a.sign ^ b.sign;
        zero_r <= (a.exp == 8'd0) || (b.exp == 8'd0);
        esum_r <= $signed({2'b00, a.exp}) + $signed({2'b00, b.exp});
      end
      if (state == NORM) Product <= result;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    valid_out = 1'b0;
    case (state)
      IDLE: if (valid_in) state_nxt = MULT;
      MULT: begin
        busy = 1'b1;
        if (mul_done) state_nxt = NORM;
      end
      NORM: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        valid_out = 1'b1;
        state_nxt = valid_in ? MULT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: doc/multiplication_fp_seq.md
Name: multiplication_fp_seq

Overview:
- Multi-cycle IEEE-754 single-precision multiplier.
- Sits directly upstream of the FP adder in the Q-update datapath; forms the products alpha*(...) and gamma*maxQ that the adder then sums.
- Uses a 24-step shift-add mantissa multiplier to save area.
- Uses the same valid_in/valid_out convention as the adder; the output is held stable so the combinational adder can consume it.

Parameters:
- BIAS, 127, exponent bias.
- MANT_W, 24, mantissa width including the hidden bit; also the number of iteration cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- InA  input  32  FP32 operand A
- InB  input  32  FP32 operand B
- valid_in  input  1  request; sampled only when not busy
- busy  output  1  high from the accepting edge until valid_out is asserted
- Product  output  32  FP32 result, held until the next result is written
- valid_out  output  1  one-cycle pulse: Product is new this cycle

Behaviour:
- Clocking/reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: Product=0, valid_out=0, busy=0, state=IDLE.
- Reset mid-operation: the operation is aborted; no valid_out is produced.
- FSM states: IDLE, MULT, NORM, DONE.
- IDLE:
  - On valid_in=1, latch InA/InB.
  - Sign = A[31]^B[31].
  - Ea + Eb as a 10-bit signed value.
  - Multiplicand = {1,A[22:0]}; multiplier = {1,B[22:0]}.
  - Clear the 48-bit accumulator and the counter; go to MULT; busy=1.
- MULT, one step per cycle:
  - If multiplier LSB=1, add the multiplicand to the upper accumulator half.
  - Shift {carry, acc, multiplier} right by 1.
  - After exactly MANT_W cycles (counter 0..23), go to NORM.
- NORM:
  - P = 48-bit product.
  - If P[47]=1: mantissa = P[46:24], E = Ea+Eb-BIAS+1.
  - Otherwise: mantissa = P[45:23], E = Ea+Eb-BIAS.
  - Rounding is truncation, no round-to-nearest; this matches the adder's truncation.
  - Special cases, in priority order:
    1. Either operand has exponent field 0 (zero/denormal): Product = {Sign, 31'd0}.
    2. E >= 255: Product = {Sign, 8'hFF, 23'd0} (saturate to infinity).
    3. E <= 0: Product = {Sign, 31'd0} (flush underflow).
    4. Otherwise: Product = {Sign, E[7:0], mantissa}.
  - Write Product; go to DONE.
- DONE: valid_out=1 for this cycle only; busy=0; go to IDLE.
- Latency:
  - Fixed, including zero and special cases.
  - Request accepted at edge k; valid_out high in the cycle after edge k+26.
  - Back-to-back: the next request can be accepted at the edge that leaves DONE (valid_in sampled in DONE as in IDLE). Throughput is 1 result per 26 cycles.
- valid_in while busy: ignored; no queueing. Inputs may change freely while busy because the operands are latched.
- NaN/Inf inputs: not supported. An exponent field of 255 is treated as an ordinary number, and the result saturates via rule 2.
- Product never tri-states. This differs from the adder: it stays driven with the last result.

Decomposition:
- Shared package fp32_pkg holds:
  - Field positions: SIGN=31, EXP 30:23, MANT 22:0.
  - BIAS=127, EXP_MAX=8'hFF, FP32_ZERO.
  - The FSM state typedef, shared with the future sequential divider.
- One natural sub-module: mant_mul_seq, the 24x24 shift-add core. Interface: start, two 24-bit operands, done, 48-bit product.
- Sign/exponent/normalise/special-case logic stays in the top.

Test Plan:
- 0x40000000 * 0x40400000 (2.0*3.0) -> Product=0x40C00000.
  - valid_out exactly 26 cycles after accept, one cycle wide; busy high in between.
- 0x3FC00000 * 0x3FC00000 (1.5*1.5) -> 0x40100000. Exercises the P[47]=1 normalise path.
- 0xBF000000 * 0x40800000 (-0.5*4.0) -> 0xC0000000.
- Zero and saturation cases:
  - 0x00000000 * 0x40490FDB -> 0x00000000.
  - 0x80000000 * 0x3F800000 -> 0x80000000.
  - 0x7F000000 * 0x7F000000 -> 0x7F800000.
  - 0x00800000 * 0x00800000 -> 0x00000000 (underflow).
- Pulse valid_in with a new operand at cycle 5 of an operation -> ignored; result matches the first operands; no extra valid_out.
- Assert rst at MULT cycle 10, then release and issue 0x3F800000*0x3F800000:
  - Outputs are 0 and busy=0 the cycle after reset.
  - Exactly one valid_out follows, with Product=0x3F800000.
